// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory responder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mem_pkg;

   // Responder FSM encodings, kept as plain constants for legacy tools
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Word geometry: byte address -> word index drops the byte offset
   localparam int MEM_WORD_BYTES = 4;
   localparam int BYTE_OFF_W     = $clog2(MEM_WORD_BYTES);

   // Response status flag values
   localparam logic RSP_ERR_NONE = 1'b0;
   localparam logic RSP_ERR_ADDR = 1'b1;

   // Address is bad when not word aligned or above the array span
   function automatic logic addr_err(input logic [31:0] addr, input int aw);
      return (addr[BYTE_OFF_W-1:0] != '0) || ((addr >> (aw + BYTE_OFF_W)) != 32'd0);
   endfunction

endpackage

// File: rtl/word_ram.sv
// Word array: synchronous write, combinational read, contents survive reset.
// Latency: write lands on the clock edge; read data follows raddr in the same cycle.
// Backpressure: none; always accepts a write when we is high.
module word_ram #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] r_mem [0:(2**AW)-1];

   // Store port: one word written per enabled edge, no reset on the array
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store port: one request at a time, word array backed.
// Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge, counting that edge.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready is seen.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_write;
   logic [31:0]       r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;

   logic              w_accept;
   logic              w_enter_resp;
   logic              w_write;
   logic [31:0]       w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_err;
   logic [ADDR_W-1:0] w_idx;
   logic              w_ram_we;
   logic [DATA_W-1:0] w_ram_rdata;

   assign w_accept     = (r_state == ST_IDLE) && req_valid;
   assign w_enter_resp = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) || (w_accept && ZERO_WAIT);

   // With zero wait states RESP is entered on the accepting edge itself, so the
   // request fields come straight from the port instead of the latched copy.
   assign w_write = w_accept ? req_write : r_write;
   assign w_addr  = w_accept ? req_addr  : r_addr;
   assign w_wdata = w_accept ? req_wdata : r_wdata;

   assign w_err    = addr_err(w_addr, ADDR_W);
   assign w_idx    = w_addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
   assign w_ram_we = w_enter_resp && w_write && !w_err;

   word_ram #(
      .AW (ADDR_W),
      .DW (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (w_ram_we),
      .waddr (w_idx),
      .wdata (w_wdata),
      .raddr (w_idx),
      .rdata (w_ram_rdata)
   );

   // Request FSM: accept, count wait states, hold the response until consumed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_write <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_write <= req_write;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  if (ZERO_WAIT) begin
                     r_state <= ST_RESP;
                  end else begin
                     r_state <= ST_WAIT;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Response payload captured on the edge entering RESP and held there
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
         r_err   <= RSP_ERR_NONE;
      end else if (w_enter_resp) begin
         r_err   <= w_err ? RSP_ERR_ADDR : RSP_ERR_NONE;
         r_rdata <= (w_err || w_write) ? '0 : w_ram_rdata;
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a queue-based scoreboard.
// Latency: checks rsp_valid rises WAIT_CYCLES+1 edges after acceptance.
// Backpressure: exercises stalled rsp_ready and a held req_valid.
module tb_data_mem_responder;

   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 32;
   localparam int WAIT_CYCLES = 2;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   int   ncyc;
   int   acc_ncyc;
   int   accepts;
   logic acc_pend;
   logic prev_vld;
   logic [31:0] hold_d;
   logic        hold_e;

   data_mem_responder #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: latency, stability while stalled, and scoreboard pop on handshake
   always @(negedge clk) begin
      exp_t e;
      ncyc++;
      if (rst) begin
         prev_vld = 1'b0;
         acc_pend = 1'b0;
      end else begin
         if (rsp_valid) begin
            checks++;
            if (req_ready !== 1'b0) begin
               errors++;
               $display("FAIL resp_req_ready: got %b want 0", req_ready);
            end
            if (!prev_vld) begin
               hold_d = rsp_rdata;
               hold_e = rsp_err;
               checks++;
               if (!acc_pend || (ncyc - acc_ncyc) != WAIT_CYCLES + 1) begin
                  errors++;
                  $display("FAIL latency: got %0d edges (pending %b) want %0d",
                           ncyc - acc_ncyc, acc_pend, WAIT_CYCLES + 1);
               end
               acc_pend = 1'b0;
            end else begin
               checks++;
               if (rsp_rdata !== hold_d || rsp_err !== hold_e) begin
                  errors++;
                  $display("FAIL rsp_stable: got %h/%b want %h/%b", rsp_rdata, rsp_err, hold_d, hold_e);
               end
            end
            if (rsp_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_rsp: got %h/%b want none", rsp_rdata, rsp_err);
               end else begin
                  e = exp_q.pop_front();
                  if (rsp_rdata !== e.rdata) begin
                     errors++;
                     $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, e.rdata);
                  end
                  checks++;
                  if (rsp_err !== e.err) begin
                     errors++;
                     $display("FAIL rsp_err: got %b want %b", rsp_err, e.err);
                  end
               end
            end
         end
         if (req_valid && req_ready) begin
            acc_pend = 1'b1;
            acc_ncyc = ncyc;
            accepts++;
         end
         prev_vld = rsp_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // One full transaction with rsp_ready high; expected response queued up front
   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee);
      int n;
      exp_q.push_back({ee, er});
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!req_ready && n < 40) begin
         tick();
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL txn_timeout: addr %h got req_ready %b want 1", a, req_ready);
         exp_q.delete();
      end
   endtask

   initial begin
      int acc0;
      int n;
      checks    = 0;
      errors    = 0;
      ncyc      = 0;
      accepts   = 0;
      acc_pend  = 1'b0;
      prev_vld  = 1'b0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      rsp_ready = 1'b1;

      // Reset then idle
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);

      // Round trip, misaligned and out-of-range accesses, last word
      do_req(1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
      do_req(1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      do_req(1'b1, 32'h11,  32'h12345678, 32'h0,        1'b1);
      do_req(1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      do_req(1'b0, 32'h400, 32'h0,        32'h0,        1'b1);
      do_req(1'b0, 32'h13,  32'h0,        32'h0,        1'b1);
      do_req(1'b1, 32'h0,   32'hAAAA5555, 32'h0,        1'b0);
      do_req(1'b1, 32'h400, 32'h0BADF00D, 32'h0,        1'b1);
      do_req(1'b0, 32'h0,   32'h0,        32'hAAAA5555, 1'b0);
      do_req(1'b1, 32'h3FC, 32'h76543210, 32'h0,        1'b0);
      do_req(1'b0, 32'h3FC, 32'h0,        32'h76543210, 1'b0);

      // Response backpressure with req_valid held through the stall
      acc0 = accepts;
      exp_q.push_back({1'b0, 32'hDEADBEEF});
      rsp_ready = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h10;
      req_valid = 1'b1;
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      for (int i = 0; i < 5; i++) tick();
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_single_accept", accepts - acc0, 32'd1);
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      tick();
      chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
      chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);

      // Reset mid-store abandons the write
      do_req(1'b1, 32'h20, 32'h11112222, 32'h0,        1'b0);
      do_req(1'b0, 32'h20, 32'h0,        32'h11112222, 1'b0);
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'hCAFEF00D;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      chk("mid_in_wait", {31'd0, req_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
      tick();
      tick();
      rst = 1'b0;
      tick();
      do_req(1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0);

      tick();
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
